qos_param: RTL and testbench
============================

Name: qos_param

Overview:
- Parametrised next-generation QoS flow controller for the switch datapath.
- Watches the status flags of one input FIFO (index 0) and NUM_CH output FIFOs (indices 1..NUM_CH).
- Drives per-channel pausa/continuar back to the producers, idle when the switch has drained, and sticky error flags.
- New over the fixed 4-channel controller: NUM_CH scaling, pause hysteresis, per-channel pause timeout, and per-FIFO error capture.

Parameters:
- NUM_CH, 4, number of output FIFOs; status vectors are NUM_CH+1 wide.
- PAUSE_TIMEOUT, 16, consecutive paused cycles that raise error_timeout; 0 disables the timeout.
- TO_W, 5, width of the per-channel pause counter; must satisfy 2^TO_W > PAUSE_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enb  in  1  clock enable; 0 freezes all state, counters and outputs.
- iniciar  in  1  start pulse; also clears an error.
- almost_full  in  NUM_CH+1  per-FIFO almost-full; bit 0 is the input FIFO.
- full  in  NUM_CH+1  per-FIFO full.
- almost_empty  in  NUM_CH+1  per-FIFO almost-empty.
- empty  in  NUM_CH+1  per-FIFO empty.
- pausa  out  NUM_CH  pausa[i] stops traffic into output FIFO i+1.
- continuar  out  NUM_CH  continuar[i] permits traffic into output FIFO i+1.
- idle  out  1  all FIFOs empty, controller running.
- error_full  out  1  sticky; some FIFO reached full.
- error_timeout  out  1  sticky; some channel stayed paused PAUSE_TIMEOUT cycles.
- error_ch  out  NUM_CH+1  sticky; bit k set means FIFO k caused an error (full or timeout).
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=INIT.
  - pausa, continuar, idle, error_full, error_timeout, error_ch all 0.
  - Pause counters cleared.
- All outputs are registered. An input sampled at edge n is visible after edge n, i.e. 1-cycle latency.
- enb=0: nothing updates, including counters; the FSM holds; inputs are ignored.
- FSM, encoding INIT=0, IDLE=1, ACTIVE=2, ERROR=3:
  - INIT: all outputs 0. iniciar=1 -> IDLE.
  - IDLE: idle=1, continuar=all 1, pausa=0, counters 0.
    - Any full bit -> ERROR.
    - Else any empty bit 0 -> ACTIVE.
  - ACTIVE: idle=0; pause logic runs.
    - Any full bit, or any timeout hit -> ERROR.
    - Else all empty bits 1 -> IDLE.
  - ERROR:
    - pausa=all 1, continuar=0, idle=0.
    - Error flags hold.
    - iniciar=1 -> INIT, clearing error_full, error_timeout, error_ch and counters in the same edge.
- Priority within one cycle: full/timeout -> ERROR beats all-empty -> IDLE.
- iniciar is ignored in IDLE and ACTIVE.
- Pause hysteresis, per channel i, ACTIVE only:
  - Set pausa[i] when almost_full[i+1] or full[i+1].
  - Clear it when almost_empty[i+1].
  - Otherwise hold.
  - If set and clear conditions coincide, set wins.
  - continuar[i] = ~pausa[i].
- Input FIFO (bit 0): affects only IDLE/ACTIVE decisions and error_full / error_ch[0]. It never drives pausa.
- Timeout counter, per channel:
  - Increments while pausa[i]=1 in ACTIVE; resets to 0 when pausa[i]=0; saturates at PAUSE_TIMEOUT.
  - When the counter reaches PAUSE_TIMEOUT, the next edge sets error_timeout and error_ch[i+1], and state becomes ERROR.
  - With PAUSE_TIMEOUT=0 the counter is inert.
- On the ERROR-entry edge:
  - error_ch |= full, plus the timeout channel bits.
  - Multiple simultaneous sources are all captured.
  - error_full and error_timeout may both be set.
- rst asserted mid-operation returns to INIT immediately, regardless of enb.

Decomposition:
- Shared package qos_pkg: state encodings INIT/IDLE/ACTIVE/ERROR and the 2-bit state width constant.
- One sub-module, qos_pause_ch, instantiated NUM_CH times by generate:
  - Contains the hysteresis flop, the TO_W-bit timeout counter and a timeout_hit output.
  - Inputs: clk, rst, enb, active, almost_full, full, almost_empty.
- The top level holds the FSM, idle and error capture.

Test Plan:
- Reset, then iniciar pulse with all empty=1 -> state INIT->IDLE one edge after iniciar; idle=1, continuar=4'b1111, pausa=0.
- From IDLE, clear empty[2] -> ACTIVE, idle=0. Then set almost_full[2] -> pausa=4'b0010 next cycle. Drop almost_full without almost_empty -> pausa stays. Assert almost_empty[2] -> pausa=0.
- PAUSE_TIMEOUT=16, hold almost_full[3] in ACTIVE -> error_timeout=1 and error_ch=5'b01000 exactly 17 edges after pausa[2] rises; state=ERROR, pausa=4'b1111.
- full[0] and full[4] asserted in the same cycle in ACTIVE -> error_full=1, error_ch=5'b10001. A following iniciar -> INIT with all error flags 0.
- enb=0 for 10 cycles while paused in ACTIVE -> counter, outputs and state unchanged. rst pulse mid-ACTIVE -> all outputs 0 and state=INIT without a clock edge.
- NUM_CH=8 instance, run the same scenario per channel -> same behaviour with 9-bit status vectors; PAUSE_TIMEOUT=0 -> no timeout after 1000 paused cycles.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared definitions for the QoS flow controller: FSM state encoding and width.
package qos_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;
endpackage

// File: rtl/qos_param_if.sv
// FIFO status / flow-control bundle between the switch datapath and the QoS controller.
interface qos_param_if #(parameter int NUM_CH = 4);
  import qos_pkg::*;

  logic              enb;
  logic              iniciar;
  logic [NUM_CH:0]   almost_full;
  logic [NUM_CH:0]   full;
  logic [NUM_CH:0]   almost_empty;
  logic [NUM_CH:0]   empty;
  logic [NUM_CH-1:0] pausa;
  logic [NUM_CH-1:0] continuar;
  logic              idle;
  logic              error_full;
  logic              error_timeout;
  logic [NUM_CH:0]   error_ch;
  logic [STATE_W-1:0] state;

  modport master (
    output enb, iniciar, almost_full, full, almost_empty, empty,
    input  pausa, continuar, idle, error_full, error_timeout, error_ch, state
  );

  modport slave (
    input  enb, iniciar, almost_full, full, almost_empty, empty,
    output pausa, continuar, idle, error_full, error_timeout, error_ch, state
  );
endinterface

// File: rtl/qos_pause_ch.sv
// One output channel: pause hysteresis flop plus saturating pause-duration counter.
module qos_pause_ch #(
  parameter int PAUSE_TIMEOUT = 16,
  parameter int TO_W          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic active,
  input  logic almost_full,
  input  logic full,
  input  logic almost_empty,
  output logic pausa,
  output logic timeout_hit
);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(PAUSE_TIMEOUT);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pausa <= 1'b0;
      cnt   <= '0;
    end else if (enb) begin
      if (!active) begin
        pausa <= 1'b0;
        cnt   <= '0;
      end else begin
        // set dominates clear when both arrive together
        if (almost_full || full)
          pausa <= 1'b1;
        else if (almost_empty)
          pausa <= 1'b0;

        if (!pausa || PAUSE_TIMEOUT == 0)
          cnt <= '0;
        else if (cnt != TO_LIM)
          cnt <= cnt + 1'b1;
      end
    end
  end

  assign timeout_hit = (PAUSE_TIMEOUT != 0) && (cnt == TO_LIM);
endmodule

// File: rtl/qos_param.sv
// QoS flow controller top: sequencing FSM, idle detect and sticky error capture
// over one input FIFO (bit 0) and NUM_CH output FIFOs.
module qos_param
  import qos_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int PAUSE_TIMEOUT = 16,
  parameter int TO_W          = 5
) (
  input logic        clk,
  input logic        rst,
  qos_param_if.slave bus
);
  state_t            st, st_nx;
  logic [NUM_CH-1:0] pause_q;
  logic [NUM_CH-1:0] hit;
  logic              err_full_q, err_full_nx;
  logic              err_to_q, err_to_nx;
  logic [NUM_CH:0]   err_ch_q, err_ch_nx;
  logic              active;
  logic              unused_in0;

  assign active     = (st == ST_ACTIVE);
  assign unused_in0 = bus.almost_full[0] ^ bus.almost_empty[0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    qos_pause_ch #(
      .PAUSE_TIMEOUT(PAUSE_TIMEOUT),
      .TO_W         (TO_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .enb         (bus.enb),
      .active      (active),
      .almost_full (bus.almost_full[i+1]),
      .full        (bus.full[i+1]),
      .almost_empty(bus.almost_empty[i+1]),
      .pausa       (pause_q[i]),
      .timeout_hit (hit[i])
    );
  end

  always_comb begin
    st_nx       = st;
    err_full_nx = err_full_q;
    err_to_nx   = err_to_q;
    err_ch_nx   = err_ch_q;
    unique case (st)
      ST_INIT:
        if (bus.iniciar) st_nx = ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        // error entry outranks the idle/active toggle
        if ((|bus.full) || (|hit)) begin
          st_nx       = ST_ERROR;
          err_full_nx = err_full_q | (|bus.full);
          err_to_nx   = err_to_q | (|hit);
          err_ch_nx   = err_ch_q | bus.full | {hit, 1'b0};
        end else if (st == ST_IDLE && !(&bus.empty)) begin
          st_nx = ST_ACTIVE;
        end else if (st == ST_ACTIVE && (&bus.empty)) begin
          st_nx = ST_IDLE;
        end
      end
      ST_ERROR:
        if (bus.iniciar) begin
          st_nx       = ST_INIT;
          err_full_nx = 1'b0;
          err_to_nx   = 1'b0;
          err_ch_nx   = '0;
        end
      default: st_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_INIT;
      err_full_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_ch_q   <= '0;
    end else if (bus.enb) begin
      st         <= st_nx;
      err_full_q <= err_full_nx;
      err_to_q   <= err_to_nx;
      err_ch_q   <= err_ch_nx;
    end
  end

  // decoded purely from flops, so no input reaches an output combinationally
  assign bus.pausa         = (st == ST_ERROR) ? '1 : (active ? pause_q : '0);
  assign bus.continuar     = (st == ST_IDLE) ? '1 : (active ? ~pause_q : '0);
  assign bus.idle          = (st == ST_IDLE);
  assign bus.error_full    = err_full_q;
  assign bus.error_timeout = err_to_q;
  assign bus.error_ch      = err_ch_q;
  assign bus.state         = st;
endmodule

// File: tb/tb_qos_param.sv
// Self-checking bench for qos_param: vector table on a 4-channel instance plus
// hand-written timeout, enable-freeze, reset and 8-channel sequences.
module tb_qos_param;
  import qos_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qos_param_if #(.NUM_CH(4)) b4 ();
  qos_param_if #(.NUM_CH(8)) b8 ();

  qos_param #(.NUM_CH(4), .PAUSE_TIMEOUT(16), .TO_W(5)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave));
  qos_param #(.NUM_CH(8), .PAUSE_TIMEOUT(0), .TO_W(5)) dut8 (
    .clk(clk), .rst(rst), .bus(b8.slave));

  typedef struct {
    logic       ini;
    logic [4:0] af, f, ae, e;
    logic [1:0] st;
    logic [3:0] pa, co;
    logic       idl, ef, et;
    logic [4:0] ech;
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic vec_t mk(logic ini, logic [4:0] af, logic [4:0] f, logic [4:0] ae,
                              logic [4:0] e, logic [1:0] st, logic [3:0] pa, logic [3:0] co,
                              logic idl, logic ef, logic et, logic [4:0] ech);
    vec_t v;
    v.ini = ini; v.af = af; v.f = f; v.ae = ae; v.e = e;
    v.st = st; v.pa = pa; v.co = co; v.idl = idl; v.ef = ef; v.et = et; v.ech = ech;
    return v;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input int unsigned st, input int unsigned pa,
                        input int unsigned co, input int unsigned idl, input int unsigned ef,
                        input int unsigned et, input int unsigned ech);
    chk({tag, ".state"}, b4.state, st);
    chk({tag, ".pausa"}, b4.pausa, pa);
    chk({tag, ".continuar"}, b4.continuar, co);
    chk({tag, ".idle"}, b4.idle, idl);
    chk({tag, ".error_full"}, b4.error_full, ef);
    chk({tag, ".error_timeout"}, b4.error_timeout, et);
    chk({tag, ".error_ch"}, b4.error_ch, ech);
  endtask

  task automatic go_active4();
    b4.iniciar = 1'b1; b4.empty = 5'h1F;
    tick();
    b4.iniciar = 1'b0; b4.empty = 5'h1B;
    tick();
    chk("go_active.state", b4.state, 2);
  endtask

  task automatic wait_err4(input int exp_edges, input string nm);
    int n = 0;
    while (!b4.error_timeout && n < 40) begin
      tick();
      n++;
    end
    chk(nm, n, exp_edges);
  endtask

  initial begin
    logic [8:0] bit9;

    b4.enb = 1'b1; b4.iniciar = 1'b0;
    b4.almost_full = '0; b4.full = '0; b4.almost_empty = '0; b4.empty = '0;
    b8.enb = 1'b1; b8.iniciar = 1'b0;
    b8.almost_full = '0; b8.full = '0; b8.almost_empty = '0; b8.empty = '0;
    rst = 1'b1;
    #12;
    check4("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset8.state", b8.state, 0);
    rst = 1'b0;
    tick();

    //           ini af     f      ae     e      st pa    co    idl ef et ech
    vq.push_back(mk(1, 5'h00, 5'h00, 5'h00, 5'h1F, 1, 4'h0, 4'hF, 1, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h00, 5'h1F, 1, 4'h0, 4'hF, 1, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h00, 5'h1B, 2, 4'h0, 4'hF, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h04, 5'h00, 5'h00, 5'h1B, 2, 4'h2, 4'hD, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h00, 5'h1B, 2, 4'h2, 4'hD, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h04, 5'h1B, 2, 4'h0, 4'hF, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h04, 5'h00, 5'h04, 5'h1B, 2, 4'h2, 4'hD, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h04, 5'h1B, 2, 4'h0, 4'hF, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h00, 5'h1F, 1, 4'h0, 4'hF, 1, 0, 0, 5'h00));
    vq.push_back(mk(1, 5'h00, 5'h00, 5'h00, 5'h1F, 1, 4'h0, 4'hF, 1, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h00, 5'h1E, 2, 4'h0, 4'hF, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h01, 5'h00, 5'h00, 5'h1E, 2, 4'h0, 4'hF, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h11, 5'h00, 5'h0E, 3, 4'hF, 4'h0, 0, 1, 0, 5'h11));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h00, 5'h1F, 3, 4'hF, 4'h0, 0, 1, 0, 5'h11));
    vq.push_back(mk(1, 5'h00, 5'h00, 5'h00, 5'h1F, 0, 4'h0, 4'h0, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h00, 5'h1F, 0, 4'h0, 4'h0, 0, 0, 0, 5'h00));
    vq.push_back(mk(1, 5'h00, 5'h00, 5'h00, 5'h1F, 1, 4'h0, 4'hF, 1, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h04, 5'h00, 5'h1F, 3, 4'hF, 4'h0, 0, 1, 0, 5'h04));
    vq.push_back(mk(1, 5'h00, 5'h00, 5'h00, 5'h1F, 0, 4'h0, 4'h0, 0, 0, 0, 5'h00));
    vq.push_back(mk(1, 5'h00, 5'h00, 5'h00, 5'h1F, 1, 4'h0, 4'hF, 1, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h00, 5'h00, 5'h1D, 2, 4'h0, 4'hF, 0, 0, 0, 5'h00));
    vq.push_back(mk(0, 5'h00, 5'h02, 5'h00, 5'h1F, 3, 4'hF, 4'h0, 0, 1, 0, 5'h02));
    vq.push_back(mk(1, 5'h00, 5'h00, 5'h00, 5'h1F, 0, 4'h0, 4'h0, 0, 0, 0, 5'h00));

    foreach (vq[i]) begin
      b4.iniciar = vq[i].ini; b4.almost_full = vq[i].af; b4.full = vq[i].f;
      b4.almost_empty = vq[i].ae; b4.empty = vq[i].e;
      tick();
      check4($sformatf("v%0d", i), vq[i].st, vq[i].pa, vq[i].co, vq[i].idl,
             vq[i].ef, vq[i].et, vq[i].ech);
    end
    b4.iniciar = 1'b0; b4.almost_full = '0; b4.full = '0; b4.almost_empty = '0;

    // timeout: error exactly 17 edges after pausa rises
    go_active4();
    b4.almost_full = 5'h08;
    tick();
    chk("to.pausa_rise", b4.pausa, 4'h4);
    wait_err4(17, "to.edges");
    check4("to.err", 3, 4'hF, 4'h0, 0, 0, 1, 5'h08);
    b4.almost_full = '0; b4.iniciar = 1'b1;
    tick();
    b4.iniciar = 1'b0;
    check4("to.clear", 0, 0, 0, 0, 0, 0, 0);

    // enb=0 freezes counter, state and outputs
    go_active4();
    b4.almost_full = 5'h08;
    tick();
    repeat (5) tick();
    b4.enb = 1'b0; b4.full = 5'h1F; b4.iniciar = 1'b1; b4.almost_empty = 5'h1F;
    repeat (10) tick();
    check4("frz", 2, 4'h4, 4'hB, 0, 0, 0, 5'h00);
    b4.full = '0; b4.iniciar = 1'b0; b4.almost_empty = '0; b4.enb = 1'b1;
    wait_err4(12, "frz.edges_left");
    chk("frz.error_ch", b4.error_ch, 5'h08);
    b4.almost_full = '0; b4.iniciar = 1'b1;
    tick();
    b4.iniciar = 1'b0;

    // async reset mid-ACTIVE, no clock edge
    go_active4();
    b4.almost_full = 5'h08;
    tick();
    chk("rst.pre_pausa", b4.pausa, 4'h4);
    #2;
    rst = 1'b1;
    #1;
    check4("rst.async", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    b4.almost_full = '0;
    tick();

    // 8-channel instance with timeout disabled
    b8.iniciar = 1'b1; b8.empty = '1;
    tick();
    chk("c8.idle", b8.idle, 1);
    chk("c8.cont_idle", b8.continuar, 8'hFF);
    b8.iniciar = 1'b0; b8.empty = 9'h1FB;
    tick();
    chk("c8.state_active", b8.state, 2);
    for (int ch = 0; ch < 8; ch++) begin
      bit9 = 9'd1 << (ch + 1);
      b8.almost_full = bit9;
      tick();
      chk($sformatf("c8.set%0d", ch), b8.pausa, 32'd1 << ch);
      b8.almost_full = '0;
      tick();
      chk($sformatf("c8.hold%0d", ch), b8.pausa, 32'd1 << ch);
      b8.almost_empty = bit9;
      tick();
      chk($sformatf("c8.clr%0d", ch), b8.pausa, 0);
      b8.almost_empty = '0;
    end
    b8.almost_full = 9'h100;
    tick();
    chk("c8.pause7", b8.pausa, 8'h80);
    repeat (1000) tick();
    chk("c8.no_to.state", b8.state, 2);
    chk("c8.no_to.flag", b8.error_timeout, 0);
    chk("c8.no_to.pausa", b8.pausa, 8'h80);
    b8.full = 9'h100;
    tick();
    chk("c8.err.state", b8.state, 3);
    chk("c8.err.ch", b8.error_ch, 9'h100);
    chk("c8.err.full", b8.error_full, 1);
    chk("c8.err.to", b8.error_timeout, 0);
    chk("c8.err.pausa", b8.pausa, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
